pwm_duty_decoder: RTL and testbench

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

---
 rtl/pwm_duty_decoder.sv | 187 ++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures the high time of a fixed-period PWM waveform
// and reports it as a 6-bit duty value once per frame. A frame whose length
// differs from PERIOD is flagged instead of decoded. A line that stops
// toggling is reported as 0 or 63 after TIMEOUT_FRAMES frames of silence.
// Optional build macro PWM_DECODE_GLITCH_FILTER_EN adds a 3-sample glitch
// filter after the synchronizer. This adds two cycles of latency and leaves
// the measured counts unchanged.
module pwm_duty_decoder #(
    parameter int PERIOD         = 64,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pwm_in,
    output logic [5:0] duty_out,
    output logic       duty_valid,
    output logic       frame_err,
    output logic       locked
);

    localparam int                 STALL_LIMIT = TIMEOUT_FRAMES * PERIOD;
    localparam int                 STALL_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_LIMIT - 1);
    localparam logic [8:0]         PERIOD_CNT  = 9'(PERIOD);

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [5:0] clip_duty(input logic [7:0] v);
        return (v > 8'd63) ? 6'd63 : v[5:0];
    endfunction

    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
    logic accept;
`ifdef PWM_DECODE_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
`endif

    state_t             state_q, state_d;
    logic [7:0]         hi_q, hi_d, lo_q, lo_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [5:0]         duty_q, duty_d;
    logic               dv_q, dv_d, fe_q, fe_d, locked_q, locked_d;
    logic               edge_seen;

    // Synchronizer, optional glitch filter and registered edge detection
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
`ifdef PWM_DECODE_GLITCH_FILTER_EN
        hist_d  = {hist_q[0], sync2_q};
        accept  = ((sync2_q == hist_q[0]) && (hist_q[0] == hist_q[1])) ? sync2_q : lvl_q;
`else
        accept  = sync2_q;
`endif
        lvl_d   = accept;
        rise_d  = accept & ~lvl_q;
        fall_d  = ~accept & lvl_q;
    end

    // Front-end flops
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`ifdef PWM_DECODE_GLITCH_FILTER_EN
            hist_q  <= 2'b00;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
`ifdef PWM_DECODE_GLITCH_FILTER_EN
            hist_q  <= hist_d;
`endif
        end
    end

    // Frame FSM: counts high/low time, closes frames and detects a static line
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_d   = stall_q;
        duty_d    = duty_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        locked_d  = locked_q;
        edge_seen = rise_q | fall_q;

        if (!enable) begin
            state_d  = IDLE;
            hi_d     = 8'd0;
            lo_d     = 8'd0;
            stall_d  = '0;
            locked_d = 1'b0;
        end else begin
            stall_d = edge_seen ? '0 : stall_q + STALL_W'(1);
            case (state_q)
                IDLE: begin
                    if (rise_q) begin
                        state_d = HIGH;
                        hi_d    = 8'd1;
                        lo_d    = 8'd0;
                    end
                end
                HIGH: begin
                    if (fall_q) begin
                        state_d = LOW;
                        lo_d    = 8'd1;
                    end else begin
                        hi_d = sat_inc(hi_q);
                    end
                end
                LOW: begin
                    if (rise_q) begin
                        if (({1'b0, hi_q} + {1'b0, lo_q}) == PERIOD_CNT) begin
                            duty_d   = clip_duty(hi_q);
                            dv_d     = 1'b1;
                            locked_d = 1'b1;
                        end else begin
                            fe_d     = 1'b1;
                            locked_d = 1'b0;
                        end
                        state_d = HIGH;
                        hi_d    = 8'd1;
                        lo_d    = 8'd0;
                    end else begin
                        lo_d = sat_inc(lo_q);
                    end
                end
                default: state_d = IDLE;
            endcase

            // A static line is reported only when no edge arrives this cycle
            if (!edge_seen && (stall_q == STALL_LAST)) begin
                duty_d   = lvl_q ? 6'd63 : 6'd0;
                dv_d     = 1'b1;
                fe_d     = 1'b0;
                locked_d = 1'b0;
                state_d  = IDLE;
                hi_d     = 8'd0;
                lo_d     = 8'd0;
                stall_d  = '0;
            end
        end
    end

    // FSM and output flops
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            stall_q  <= '0;
            duty_q   <= 6'd0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            stall_q  <= stall_d;
            duty_q   <= duty_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
            locked_q <= locked_d;
        end
    end

    assign duty_out   = duty_q;
    assign duty_valid = dv_q;
    assign frame_err  = fe_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: drives PWM frames from a table plus hand-written
// corner sequences; expected pulses go into a scoreboard queue when the
// stimulus is driven and are matched against duty_valid/frame_err.
module tb_pwm_duty_decoder;

`ifdef PWM_DECODE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int TO = 128;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic       pwm_in = 1'b0;
    logic [5:0] duty_out;
    logic       duty_valid, frame_err, locked;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         cyc;
        bit         err;
        logic [5:0] duty;
        bit         lck;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int         hi;
        int         lo;
        int         n;
        bit         err;
        logic [5:0] duty;
    } vec_t;
    vec_t tbl[9];

    bit         pend = 1'b0;
    bit         pend_err = 1'b0;
    logic [5:0] pend_duty = 6'd0;

    pwm_duty_decoder #(.PERIOD(64), .TIMEOUT_FRAMES(2)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .duty_valid(duty_valid),
        .frame_err (frame_err),
        .locked    (locked)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_pulse(input int dly, input bit err, input logic [5:0] duty, input bit lck);
        exp_t e;
        e.cyc  = cyc + dly;
        e.err  = err;
        e.duty = duty;
        e.lck  = lck;
        sbq.push_back(e);
    endtask

    // Rising edge; closes the pending frame if one is open
    task automatic drive_rise();
        if (pend) expect_pulse(LAT + 1, pend_err, pend_duty, !pend_err);
        pwm_in = 1'b1;
    endtask

    task automatic frame(input int hi, input int lo, input bit err, input logic [5:0] duty);
        drive_rise();
        repeat (hi) @(negedge sysclk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge sysclk);
        pend      = 1'b1;
        pend_err  = err;
        pend_duty = duty;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge sysclk) begin
        exp_t e;
        if (!reset) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("missed_pulse_at_cycle", cyc, e.cyc);
            end
            if (duty_valid || frame_err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, frame_err, duty_valid}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind_fe_dv", {30'd0, frame_err, duty_valid}, e.err ? 2 : 1);
                    chk("pulse_duty", int'(duty_out), int'(e.duty));
                    chk("pulse_locked", int'(locked), int'(e.lck));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{20, 44, 3, 1'b0, 6'd20};
        tbl[1] = '{20, 43, 3, 1'b1, 6'd20};
        tbl[2] = '{30, 34, 2, 1'b0, 6'd30};
        tbl[3] = '{63,  1, 2, 1'b0, 6'd63};
        tbl[4] = '{ 1, 63, 2, 1'b0, 6'd1};
        tbl[5] = '{50, 20, 1, 1'b1, 6'd1};
        tbl[6] = '{40, 24, 2, 1'b0, 6'd40};
        tbl[7] = '{10, 10, 1, 1'b1, 6'd40};
        tbl[8] = '{20, 44, 1, 1'b0, 6'd20};

        // Reset state
        repeat (3) @(negedge sysclk);
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_valid", int'(duty_valid), 0);
        chk("reset_err", int'(frame_err), 0);
        chk("reset_locked", int'(locked), 0);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        // Table-driven frames
        for (int i = 0; i < 9; i++)
            for (int k = 0; k < tbl[i].n; k++)
                frame(tbl[i].hi, tbl[i].lo, tbl[i].err, tbl[i].duty);

        // Lock, then hold low: timeout reports 0
        drive_rise();
        pend = 1'b0;
        repeat (20) @(negedge sysclk);
        chk("locked_before_hold_low", int'(locked), 1);
        pwm_in = 1'b0;
        expect_pulse(LAT + 1 + TO, 1'b0, 6'd0, 1'b0);
        repeat (200) @(negedge sysclk);
        chk("hold_low_duty", int'(duty_out), 0);
        chk("hold_low_locked", int'(locked), 0);

        // Hold high: timeout reports 63; first rise after idle gives no pulse
        pwm_in = 1'b1;
        expect_pulse(LAT + 1 + TO, 1'b0, 6'd63, 1'b0);
        repeat (200) @(negedge sysclk);
        chk("hold_high_duty", int'(duty_out), 63);
        pwm_in = 1'b0;
        repeat (5) @(negedge sysclk);

        // Reset in the middle of a high phase
        for (int k = 0; k < 3; k++) frame(30, 34, 1'b0, 6'd30);
        drive_rise();
        pend = 1'b0;
        repeat (10) @(negedge sysclk);
        chk("locked_before_reset", int'(locked), 1);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("midreset_duty", int'(duty_out), 0);
        chk("midreset_locked", int'(locked), 0);
        repeat (18) @(negedge sysclk);
        pwm_in = 1'b0;
        repeat (5) @(negedge sysclk);
        reset = 1'b0;
        repeat (29) @(negedge sysclk);
        frame(30, 34, 1'b0, 6'd30);
        frame(30, 34, 1'b0, 6'd30);

        // Disable while locked, frame in progress is dropped
        drive_rise();
        pend = 1'b0;
        repeat (30) @(negedge sysclk);
        pwm_in = 1'b0;
        repeat (34) @(negedge sysclk);
        chk("locked_before_disable", int'(locked), 1);
        enable = 1'b0;
        repeat (20) @(negedge sysclk);
        chk("disabled_locked", int'(locked), 0);
        chk("disabled_duty_held", int'(duty_out), 30);
        enable = 1'b1;
        repeat (3) @(negedge sysclk);
        frame(30, 34, 1'b0, 6'd30);
        frame(30, 34, 1'b0, 6'd30);

        // One-cycle low glitch inside a 40-cycle high phase
        drive_rise();
        repeat (10) @(negedge sysclk);
        pwm_in = 1'b0;
        @(negedge sysclk);
`ifdef PWM_DECODE_GLITCH_FILTER_EN
        pwm_in = 1'b1;
        pend = 1'b1; pend_err = 1'b0; pend_duty = 6'd40;
`else
        pend = 1'b1; pend_err = 1'b1; pend_duty = 6'd30;
        drive_rise();
`endif
        repeat (29) @(negedge sysclk);
        pwm_in = 1'b0;
        repeat (24) @(negedge sysclk);
        frame(20, 44, 1'b0, 6'd20);
        drive_rise();
        pend = 1'b0;
        repeat (LAT + 8) @(negedge sysclk);
        chk("final_duty", int'(duty_out), 20);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
